// File: rtl/pipeline_control_pkg.sv
// Shared definitions for the five-stage pipeline control slice: opcodes,
// control-bundle bit positions and the canonical bundle values.
package pipeline_control_pkg;

    localparam int CTRL_W = 11;

    localparam int B_REG2_SEL    = 10;
    localparam int B_MEM_READ    = 9;
    localparam int B_MEM_WRITE   = 8;
    localparam int B_MEM_TO_REG  = 7;
    localparam int B_REG_WRITE   = 6;
    localparam int B_BR_ZERO     = 5;
    localparam int B_BRANCH      = 4;
    localparam int B_BR_NOT_ZERO = 3;
    localparam int B_ALU_SRC     = 2;
    localparam int B_ALU_OP_HI   = 1;
    localparam int B_ALU_OP_LO   = 0;

    typedef logic [CTRL_W-1:0] ctrl_t;

    // Full 11-bit opcodes; branch and immediate forms are matched on a prefix only
    localparam logic [10:0] OP_ADD   = 11'b10001011000;
    localparam logic [10:0] OP_SUB   = 11'b11001011000;
    localparam logic [10:0] OP_AND   = 11'b10001010000;
    localparam logic [10:0] OP_ORR   = 11'b10101010000;
    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_LDURB = 11'b00111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI  = 10'b1101000100;

    localparam ctrl_t CTRL_NOP   = 11'b00000000000;
    localparam ctrl_t CTRL_RTYPE = 11'b00001000010;
    localparam ctrl_t CTRL_LOAD  = 11'b01011000100;
    localparam ctrl_t CTRL_STORE = 11'b10100000100;
    localparam ctrl_t CTRL_CBZ   = 11'b10000100001;
    localparam ctrl_t CTRL_CBNZ  = 11'b10000001001;
    localparam ctrl_t CTRL_B     = 11'b00000010000;
    localparam ctrl_t CTRL_IMM   = 11'b00001000111;

endpackage

// File: rtl/pipeline_control_if.sv
// Bundles the IF/ID inputs and all stage/hazard/counter outputs of pipeline_control.
interface pipeline_control_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    import pipeline_control_pkg::*;

    logic [31:0]       instr;
    logic              ifid_valid;
    logic              flush;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CTRL_W-1:0] mem_ctrl;
    logic [CTRL_W-1:0] wb_ctrl;
    logic [REG_AW-1:0] ex_rd;
    logic [REG_AW-1:0] mem_rd;
    logic [REG_AW-1:0] wb_rd;
    logic              stall;
    logic              pc_write;
    logic              ifid_write;
    logic              ifid_flush;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output instr, ifid_valid, flush,
        input  ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd,
        input  stall, pc_write, ifid_write, ifid_flush, stall_cnt, flush_cnt
    );

    modport slave (
        input  instr, ifid_valid, flush,
        output ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd,
        output stall, pc_write, ifid_write, ifid_flush, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_control_ctrl_decode.sv
// Combinational opcode decode: produces the control bundle and whether the
// instruction reads a second source register.
module ctrl_decode
    import pipeline_control_pkg::*;
#(
    parameter int EN_IMM = 1
) (
    input  logic [31:0] instr,
    output ctrl_t       bundle,
    output logic        uses_src2
);

    logic [10:0] op;
    logic        unused_fields;

    assign op            = instr[31:21];
    assign unused_fields = ^instr[20:0];

    // Unrecognised opcodes fall through to an all-zero bundle
    always_comb begin
        bundle    = CTRL_NOP;
        uses_src2 = 1'b0;
        if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) begin
            bundle    = CTRL_RTYPE;
            uses_src2 = 1'b1;
        end else if (op == OP_LDUR || op == OP_LDURB) begin
            bundle = CTRL_LOAD;
        end else if (op == OP_STUR) begin
            bundle    = CTRL_STORE;
            uses_src2 = 1'b1;
        end else if (op[10:3] == OP_CBZ) begin
            bundle    = CTRL_CBZ;
            uses_src2 = 1'b1;
        end else if (op[10:3] == OP_CBNZ) begin
            bundle    = CTRL_CBNZ;
            uses_src2 = 1'b1;
        end else if (op[10:5] == OP_B) begin
            bundle = CTRL_B;
        end else if (EN_IMM != 0 && (op[10:1] == OP_ADDI || op[10:1] == OP_SUBI)) begin
            bundle = CTRL_IMM;
        end
    end

endmodule

// File: rtl/pipeline_control.sv
// Pipeline control: decode, load-use hazard detection with flush priority,
// ID/EX -> EX/MEM -> MEM/WB control registers and saturating event counters.
module pipeline_control
    import pipeline_control_pkg::*;
#(
    parameter int REG_AW    = 5,
    parameter int EN_IMM    = 1,
    parameter int HAZARD_EN = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    pipeline_control_if.slave bus
);

    localparam logic [REG_AW-1:0] NO_REG = REG_AW'(31);

    ctrl_t             dec_bundle;
    logic              uses_src2;
    logic [REG_AW-1:0] rn;
    logic [REG_AW-1:0] src2;
    logic              hazard;
    logic              stall;

    ctrl_t             ex_ctrl_q, mem_ctrl_q, wb_ctrl_q;
    logic [REG_AW-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

    ctrl_decode #(.EN_IMM(EN_IMM)) u_decode (
        .instr     (bus.instr),
        .bundle    (dec_bundle),
        .uses_src2 (uses_src2)
    );

    assign rn   = REG_AW'(bus.instr[9:5]);
    assign src2 = dec_bundle[B_REG2_SEL] ? REG_AW'(bus.instr[4:0]) : REG_AW'(bus.instr[20:16]);

    // A load into X31 never creates a dependency; a flush suppresses the stall
    always_comb begin
        hazard = ex_ctrl_q[B_MEM_READ] && (ex_rd_q != NO_REG) &&
                 ((ex_rd_q == rn) || (uses_src2 && (ex_rd_q == src2)));
        stall  = (HAZARD_EN != 0) && bus.ifid_valid && !bus.flush && hazard;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_ctrl_q  <= CTRL_NOP;
            mem_ctrl_q <= CTRL_NOP;
            wb_ctrl_q  <= CTRL_NOP;
            ex_rd_q    <= NO_REG;
            mem_rd_q   <= NO_REG;
            wb_rd_q    <= NO_REG;
        end else begin
            if (stall || bus.flush || !bus.ifid_valid) begin
                ex_ctrl_q <= CTRL_NOP;
                ex_rd_q   <= NO_REG;
            end else begin
                ex_ctrl_q <= dec_bundle;
                ex_rd_q   <= REG_AW'(bus.instr[4:0]);
            end
            mem_ctrl_q <= ex_ctrl_q;
            mem_rd_q   <= ex_rd_q;
            wb_ctrl_q  <= mem_ctrl_q;
            wb_rd_q    <= mem_rd_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (bus.flush && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.ex_ctrl    = ex_ctrl_q;
    assign bus.mem_ctrl   = mem_ctrl_q;
    assign bus.wb_ctrl    = wb_ctrl_q;
    assign bus.ex_rd      = ex_rd_q;
    assign bus.mem_rd     = mem_rd_q;
    assign bus.wb_rd      = wb_rd_q;
    assign bus.stall      = stall;
    assign bus.pc_write   = ~stall;
    assign bus.ifid_write = ~stall;
    assign bus.ifid_flush = bus.flush;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench: two pipeline_control instances (defaults, and EN_IMM=0 with
// 4-bit counters) share stimulus and are checked every cycle against a rule-table model.
module tb_pipeline_control;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b1;
    logic [31:0] instr      = '0;
    logic        ifid_valid = 1'b0;
    logic        flush      = 1'b0;

    int n_vectors     = 0;
    int n_miscompares = 0;

    always #5 clk = ~clk;

    pipeline_control_if #(.REG_AW(5), .CNT_W(16)) bus0 ();
    pipeline_control_if #(.REG_AW(5), .CNT_W(4))  bus1 ();

    assign bus0.instr      = instr;
    assign bus0.ifid_valid = ifid_valid;
    assign bus0.flush      = flush;
    assign bus1.instr      = instr;
    assign bus1.ifid_valid = ifid_valid;
    assign bus1.flush      = flush;

    pipeline_control #(.REG_AW(5), .EN_IMM(1), .HAZARD_EN(1), .CNT_W(16)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0));
    pipeline_control #(.REG_AW(5), .EN_IMM(0), .HAZARD_EN(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1));

    // Instruction classes as (pattern, mask) on instr[31:21]; src2: 0 none, 1 Rm, 2 Rt
    typedef struct packed {
        logic [10:0] pat;
        logic [10:0] msk;
        logic [10:0] bnd;
        logic [1:0]  src2;
        logic        imm;
    } rule_t;

    rule_t rules [12];
    int    cnt_max [2]  = '{65535, 15};
    int    en_imm_p [2] = '{1, 0};
    string stage_name [3] = '{"ex", "mem", "wb"};

    logic [10:0] m_ctrl [2][3];
    logic [4:0]  m_rd   [2][3];
    int          m_scnt [2];
    int          m_fcnt [2];

    logic [10:0] a_ctrl [2][3];
    logic [4:0]  a_rd   [2][3];
    logic [15:0] a_scnt [2];
    logic [15:0] a_fcnt [2];
    logic        a_stall [2];
    logic        a_pcw [2];
    logic        a_ifw [2];
    logic        a_iff [2];

    always_comb begin
        a_ctrl[0] = '{bus0.ex_ctrl, bus0.mem_ctrl, bus0.wb_ctrl};
        a_ctrl[1] = '{bus1.ex_ctrl, bus1.mem_ctrl, bus1.wb_ctrl};
        a_rd[0]   = '{bus0.ex_rd, bus0.mem_rd, bus0.wb_rd};
        a_rd[1]   = '{bus1.ex_rd, bus1.mem_rd, bus1.wb_rd};
        a_scnt[0] = bus0.stall_cnt;
        a_scnt[1] = 16'(bus1.stall_cnt);
        a_fcnt[0] = bus0.flush_cnt;
        a_fcnt[1] = 16'(bus1.flush_cnt);
        a_stall   = '{bus0.stall, bus1.stall};
        a_pcw     = '{bus0.pc_write, bus1.pc_write};
        a_ifw     = '{bus0.ifid_write, bus1.ifid_write};
        a_iff     = '{bus0.ifid_flush, bus1.ifid_flush};
    end

    function automatic rule_t mk(input logic [10:0] p, input logic [10:0] m,
                                 input logic [10:0] b, input logic [1:0] s, input logic i);
        rule_t r;
        r.pat  = p;
        r.msk  = m;
        r.bnd  = b;
        r.src2 = s;
        r.imm  = i;
        return r;
    endfunction

    initial begin
        rules[0]  = mk(11'b10001011000, 11'b11111111111, 11'b00001000010, 2'd1, 1'b0);
        rules[1]  = mk(11'b11001011000, 11'b11111111111, 11'b00001000010, 2'd1, 1'b0);
        rules[2]  = mk(11'b10001010000, 11'b11111111111, 11'b00001000010, 2'd1, 1'b0);
        rules[3]  = mk(11'b10101010000, 11'b11111111111, 11'b00001000010, 2'd1, 1'b0);
        rules[4]  = mk(11'b11111000010, 11'b11111111111, 11'b01011000100, 2'd0, 1'b0);
        rules[5]  = mk(11'b00111000010, 11'b11111111111, 11'b01011000100, 2'd0, 1'b0);
        rules[6]  = mk(11'b11111000000, 11'b11111111111, 11'b10100000100, 2'd2, 1'b0);
        rules[7]  = mk(11'b10110100000, 11'b11111111000, 11'b10000100001, 2'd2, 1'b0);
        rules[8]  = mk(11'b10110101000, 11'b11111111000, 11'b10000001001, 2'd2, 1'b0);
        rules[9]  = mk(11'b00010100000, 11'b11111100000, 11'b00000010000, 2'd0, 1'b0);
        rules[10] = mk(11'b10010001000, 11'b11111111110, 11'b00001000111, 2'd0, 1'b1);
        rules[11] = mk(11'b11010001000, 11'b11111111110, 11'b00001000111, 2'd0, 1'b1);
    end

    function automatic void model_decode(input int d, input logic [31:0] ins,
                                         output logic [10:0] bnd, output logic [4:0] s2,
                                         output logic has_s2);
        bnd    = '0;
        s2     = '0;
        has_s2 = 1'b0;
        foreach (rules[k]) begin
            if (((ins[31:21] & rules[k].msk) == rules[k].pat) && (!rules[k].imm || en_imm_p[d] != 0)) begin
                bnd    = rules[k].bnd;
                has_s2 = (rules[k].src2 != 2'd0);
                s2     = (rules[k].src2 == 2'd1) ? ins[20:16] : ins[4:0];
            end
        end
    endfunction

    function automatic logic model_stall(input int d);
        logic [10:0] b;
        logic [4:0]  s2;
        logic        hs;
        logic [4:0]  erd;
        model_decode(d, instr, b, s2, hs);
        erd = m_rd[d][0];
        return ifid_valid && !flush && m_ctrl[d][0][9] && (erd != 5'd31) &&
               ((erd == instr[9:5]) || (hs && erd == s2));
    endfunction

    function automatic void model_reset(input int d);
        for (int j = 0; j < 3; j++) begin
            m_ctrl[d][j] = '0;
            m_rd[d][j]   = 5'd31;
        end
        m_scnt[d] = 0;
        m_fcnt[d] = 0;
    endfunction

    function automatic void model_step(input int d, input logic st);
        logic [10:0] b;
        logic [4:0]  s2;
        logic        hs;
        model_decode(d, instr, b, s2, hs);
        if (st && m_scnt[d] < cnt_max[d]) m_scnt[d]++;
        if (flush && m_fcnt[d] < cnt_max[d]) m_fcnt[d]++;
        for (int j = 2; j > 0; j--) begin
            m_ctrl[d][j] = m_ctrl[d][j-1];
            m_rd[d][j]   = m_rd[d][j-1];
        end
        if (st || flush || !ifid_valid) begin
            m_ctrl[d][0] = '0;
            m_rd[d][0]   = 5'd31;
        end else begin
            m_ctrl[d][0] = b;
            m_rd[d][0]   = instr[4:0];
        end
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] ins, input logic v, input logic f);
        instr      = ins;
        ifid_valid = v;
        flush      = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc(input logic [10:0] op, input logic [4:0] rm,
                                        input logic [4:0] rn, input logic [4:0] rd);
        return {op, rm, 6'b000000, rn, rd};
    endfunction

    function automatic logic [4:0] rand_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    function automatic logic [31:0] rand_instr();
        int k;
        logic [10:0] op;
        k = $urandom_range(0, 12);
        if (k == 12) return $urandom();
        op = rules[k].pat | (11'($urandom) & ~rules[k].msk);
        return {op, rand_reg(), 6'($urandom), rand_reg(), rand_reg()};
    endfunction

    // Per-cycle comparison against the model; inputs only change just after a rising edge
    initial begin
        logic st;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!reset_n) model_reset(d);
                st = model_stall(d);
                for (int j = 0; j < 3; j++) begin
                    checkOutput($sformatf("dut%0d %s_ctrl", d, stage_name[j]), 64'(a_ctrl[d][j]), 64'(m_ctrl[d][j]));
                    checkOutput($sformatf("dut%0d %s_rd", d, stage_name[j]), 64'(a_rd[d][j]), 64'(m_rd[d][j]));
                end
                checkOutput($sformatf("dut%0d stall", d), 64'(a_stall[d]), 64'(st));
                checkOutput($sformatf("dut%0d pc_write", d), 64'(a_pcw[d]), 64'(!st));
                checkOutput($sformatf("dut%0d ifid_write", d), 64'(a_ifw[d]), 64'(!st));
                checkOutput($sformatf("dut%0d ifid_flush", d), 64'(a_iff[d]), 64'(flush));
                checkOutput($sformatf("dut%0d stall_cnt", d), 64'(a_scnt[d]), 64'(m_scnt[d]));
                checkOutput($sformatf("dut%0d flush_cnt", d), 64'(a_fcnt[d]), 64'(m_fcnt[d]));
                if (reset_n) model_step(d, st);
            end
        end
    end

    initial begin
        logic [31:0] add_1_2_3, ldur_x5, add_6_5_7, ldur_x31, add_6_31_7, addi_4_2;
        add_1_2_3  = enc(11'b10001011000, 5'd3, 5'd2, 5'd1);
        ldur_x5    = enc(11'b11111000010, 5'd0, 5'd1, 5'd5);
        add_6_5_7  = enc(11'b10001011000, 5'd7, 5'd5, 5'd6);
        ldur_x31   = enc(11'b11111000010, 5'd0, 5'd1, 5'd31);
        add_6_31_7 = enc(11'b10001011000, 5'd7, 5'd31, 5'd6);
        addi_4_2   = enc(11'b10010001000, 5'd0, 5'd2, 5'd4);

        #1 reset_n = 1'b0;
        #1;
        checkOutput("reset ex_ctrl", 64'(bus0.ex_ctrl), 64'd0);
        checkOutput("reset wb_rd", 64'(bus0.wb_rd), 64'd31);
        checkOutput("reset stall_cnt", 64'(bus0.stall_cnt), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        applyStimulus(add_1_2_3, 1'b1, 1'b0);
        tick();
        checkOutput("add ex_ctrl", 64'(bus0.ex_ctrl), 64'(11'b00001000010));
        checkOutput("add ex_rd", 64'(bus0.ex_rd), 64'd1);
        applyStimulus('0, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("add wb_ctrl", 64'(bus0.wb_ctrl), 64'(11'b00001000010));
        checkOutput("add wb_rd", 64'(bus0.wb_rd), 64'd1);

        applyStimulus(ldur_x5, 1'b1, 1'b0);
        tick();
        applyStimulus(add_6_5_7, 1'b1, 1'b0);
        #1;
        checkOutput("loaduse stall", 64'(bus0.stall), 64'd1);
        checkOutput("loaduse pc_write", 64'(bus0.pc_write), 64'd0);
        tick();
        checkOutput("loaduse bubble ex_ctrl", 64'(bus0.ex_ctrl), 64'd0);
        checkOutput("loaduse bubble ex_rd", 64'(bus0.ex_rd), 64'd31);
        checkOutput("loaduse stall_cnt", 64'(bus0.stall_cnt), 64'd1);

        applyStimulus(ldur_x31, 1'b1, 1'b0);
        tick();
        applyStimulus(add_6_31_7, 1'b1, 1'b0);
        #1;
        checkOutput("x31 no stall", 64'(bus0.stall), 64'd0);
        tick();

        applyStimulus(ldur_x5, 1'b1, 1'b0);
        tick();
        applyStimulus(add_6_5_7, 1'b1, 1'b1);
        #1;
        checkOutput("flush beats stall", 64'(bus0.stall), 64'd0);
        checkOutput("flush ifid_flush", 64'(bus0.ifid_flush), 64'd1);
        tick();
        checkOutput("flush ex_ctrl", 64'(bus0.ex_ctrl), 64'd0);
        checkOutput("flush flush_cnt", 64'(bus0.flush_cnt), 64'd1);
        checkOutput("flush stall_cnt", 64'(bus0.stall_cnt), 64'd1);

        applyStimulus(addi_4_2, 1'b1, 1'b0);
        tick();
        checkOutput("addi en_imm=1", 64'(bus0.ex_ctrl), 64'(11'b00001000111));
        checkOutput("addi en_imm=0", 64'(bus1.ex_ctrl), 64'd0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(ldur_x5, 1'b1, 1'b0);
            tick();
            applyStimulus(add_6_5_7, 1'b1, 1'b0);
            tick();
        end
        checkOutput("20 stalls cnt16", 64'(bus0.stall_cnt), 64'd21);
        checkOutput("20 stalls cnt4 saturate", 64'(bus1.stall_cnt), 64'd15);

        applyStimulus(ldur_x5, 1'b1, 1'b0);
        reset_n = 1'b0;
        #1;
        checkOutput("midrun reset mem_ctrl", 64'(bus0.mem_ctrl), 64'd0);
        checkOutput("midrun reset ex_rd", 64'(bus0.ex_rd), 64'd31);
        checkOutput("midrun reset stall_cnt", 64'(bus1.stall_cnt), 64'd0);
        checkOutput("midrun reset flush_cnt", 64'(bus0.flush_cnt), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            reset_n = ($urandom_range(0, 59) != 0);
            applyStimulus(rand_instr(), ($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0));
            tick();
        end
        reset_n = 1'b1;
        applyStimulus('0, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter EN_IMM, default 1; 1 decodes ADDI/SUBI, 0 treats them as illegal (all-zero control).
REQ-003 SHALL have parameter HAZARD_EN, default 1; 0 forces stall low permanently.
REQ-004 SHALL have parameter CNT_W, default 16, performance-counter width.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port instr, input, 32, IF/ID instruction.
REQ-008 SHALL have port ifid_valid, input, 1, instr holds a live instruction.
REQ-009 SHALL have port flush, input, 1, taken branch resolved in EX this cycle.
REQ-010 SHALL have ports ex_ctrl, mem_ctrl and wb_ctrl, output, 11 each, registered control bundles of the ID/EX, EX/MEM and MEM/WB stages.
REQ-011 SHALL have ports ex_rd, mem_rd and wb_rd, output, REG_AW each, destination register per stage.
REQ-012 SHALL have port stall, output, 1, combinational load-use hazard indication.
REQ-013 SHALL have ports pc_write and ifid_write, output, 1 each, both equal to the inverse of stall.
REQ-014 SHALL have port ifid_flush, output, 1, equal to flush.
REQ-015 SHALL have ports stall_cnt and flush_cnt, output, CNT_W each, saturating event counters.

Function
REQ-016 Bundle bit order SHALL be [10] reg2_sel, [9] mem_read, [8] mem_write, [7] mem_to_reg, [6] reg_write, [5] branch_if_zero, [4] branch, [3] branch_if_not_zero, [2] alu_src, [1:0] alu_op.
REQ-017 Decode on instr[31:21] SHALL use these opcodes: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, LDURB 00111000010, STUR 11111000000, CBZ 10110100xxx, CBNZ 10110101xxx, B 000101xxxxx, ADDI 1001000100x, SUBI 1101000100x.
REQ-018 Decoded bundles SHALL be: R-type 00001000010; loads 01011000100; STUR 10100000100; CBZ 10000100001; CBNZ 10000001001; B 00000010000; ADDI/SUBI 00001000111; any other opcode 00000000000.
REQ-019 Register fields SHALL be Rn=instr[9:5], Rm=instr[20:16], Rt/Rd=instr[4:0]; source 2 SHALL be Rt when reg2_sel=1 and Rm for R-type; I-type, loads and B SHALL have no source 2.
REQ-020 stall SHALL be 1 iff HAZARD_EN, ifid_valid, flush=0, ex_ctrl[9]=1, ex_rd!=31, and ex_rd equals Rn or the used source 2.
REQ-021 On each edge, ID/EX SHALL load zero bundle and rd 31 if stall, flush or !ifid_valid, otherwise the decoded bundle and instr[4:0].
REQ-022 EX/MEM SHALL load ID/EX unconditionally, and MEM/WB SHALL load EX/MEM unconditionally (latency decode-to-wb_ctrl 3 cycles).
REQ-023 When flush and stall conditions coincide, flush SHALL win: stall=0, bubble inserted.
REQ-024 stall_cnt SHALL increment on each cycle with stall=1, and flush_cnt on each cycle with flush=1; both SHALL saturate at all-ones without wrap.

Reset
REQ-025 While reset_n=0, all ctrl outputs SHALL be 0, all rd outputs 31 and both counters 0, regardless of clk.
REQ-026 Deassertion mid-stream SHALL restart from empty pipeline; the first edge after deassertion loads ID/EX per REQ-021.

Structure
REQ-027 A shared package SHALL hold the opcode constants, bundle bit indices, the CTRL_W=11 constant and the named bundle values.
REQ-028 Combinational decode SHALL be a sub-module ctrl_decode (instr, EN_IMM -> bundle, uses_src2); hazard logic, stage registers and counters SHALL reside in pipeline_control.

Verification
REQ-029 ADD X1,X2,X3 with ifid_valid=1 -> ex_ctrl=00001000010, ex_rd=1 after 1 edge; wb_ctrl equal after 3 edges.
REQ-030 LDUR X5 in EX, then ADD X6,X5,X7 in ID -> stall=1, pc_write=0, next ex_ctrl=0, stall_cnt +1.
REQ-031 LDUR X31 in EX, then ADD reading X31 -> stall=0.
REQ-032 Hazard pair of REQ-030 with flush=1 -> stall=0, ex_ctrl=0 next edge, flush_cnt +1, stall_cnt unchanged.
REQ-033 EN_IMM=0, ADDI opcode -> ex_ctrl=0; EN_IMM=1 -> 00001000111.
REQ-034 CNT_W=4, 20 consecutive stalls -> stall_cnt=15; reset_n low mid-run -> all outputs per REQ-025 immediately.
